// File: rtl/detector_pkg.sv
// Shared definitions for the passage-direction detector: FSM encoding and debounce default.
// Combinational constants only; no latency or flow control involved.
package detector_pkg;

   localparam int DEB_CYCLES_DEF = 4;

   // Entry path ENTx: outer beam first; exit path SALx: inner beam first.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ENT1 = 3'd1,
      ENT2 = 3'd2,
      ENT3 = 3'd3,
      SAL1 = 3'd4,
      SAL2 = 3'd5,
      SAL3 = 3'd6,
      ERR  = 3'd7
   } estado_t;

endpackage

// File: rtl/filtro_rebote.sv
// Beam sensor conditioner: 2-flop synchronizer, plus a debounce filter when DETECTOR_DEBOUNCE_EN is defined.
// Latency 2 clocks (sync only) or 2+DEB_CYCLES clocks (debounced); no backpressure, free-running.
module filtro_rebote
   import detector_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_rango
      $error("filtro_rebote: DEB_CYCLES out of range 1..255");
   end

   logic sync1;
   logic sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

`ifdef DETECTOR_DEBOUNCE_EN
   localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

   logic [7:0] cnt;
   logic       filt;

   // The filtered value only flips once the synchronized input has disagreed
   // with it for DEB_CYCLES clocks in a row; any agreement restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (sync2 != filt) begin
         if (cnt == CNT_MAX) begin
            filt <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end else begin
         cnt <= '0;
      end
   end

   assign dout = filt;
`else
   assign dout = sync2;
`endif

endmodule

// File: rtl/detector_sentido.sv
// Two-beam passage direction detector: one-cycle s on entry, r on exit, err on illegal sequence (DETECTOR_DEBOUNCE_EN adds input debounce).
// Pulses appear 1 clock after the FSM sees the completing transition; no backpressure, pulses are fire-and-forget.
module detector_sentido
   import detector_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sa,
   input  logic sb,
   output logic s,
   output logic r,
   output logic err
);

   logic       fa;
   logic       fb;
   logic [1:0] par;
   estado_t    estado;
   estado_t    estado_sig;
   logic       s_sig;
   logic       r_sig;
   logic       err_sig;

   filtro_rebote #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_a (
      .clk  (clk),
      .rst  (rst),
      .din  (sa),
      .dout (fa)
   );

   filtro_rebote #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_b (
      .clk  (clk),
      .rst  (rst),
      .din  (sb),
      .dout (fb)
   );

   assign par = {fa, fb};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado <= IDLE;
         s      <= 1'b0;
         r      <= 1'b0;
         err    <= 1'b0;
      end else begin
         estado <= estado_sig;
         s      <= s_sig;
         r      <= r_sig;
         err    <= err_sig;
      end
   end

   // Each state lists its legal beam pairs; anything else lands in ERR.
   always_comb begin
      estado_sig = estado;
      s_sig      = 1'b0;
      r_sig      = 1'b0;
      err_sig    = 1'b0;
      case (estado)
         IDLE: begin
            case (par)
               2'b10:   estado_sig = ENT1;
               2'b01:   estado_sig = SAL1;
               2'b11: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
               default: estado_sig = IDLE;
            endcase
         end
         ENT1: begin
            case (par)
               2'b10: estado_sig = ENT1;
               2'b11: estado_sig = ENT2;
               2'b00: estado_sig = IDLE;
               default: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
            endcase
         end
         ENT2: begin
            case (par)
               2'b11: estado_sig = ENT2;
               2'b01: estado_sig = ENT3;
               2'b10: estado_sig = ENT1;
               default: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
            endcase
         end
         ENT3: begin
            case (par)
               2'b01: estado_sig = ENT3;
               2'b00: begin
                  estado_sig = IDLE;
                  s_sig      = 1'b1;
               end
               2'b11: estado_sig = ENT2;
               default: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
            endcase
         end
         SAL1: begin
            case (par)
               2'b01: estado_sig = SAL1;
               2'b11: estado_sig = SAL2;
               2'b00: estado_sig = IDLE;
               default: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
            endcase
         end
         SAL2: begin
            case (par)
               2'b11: estado_sig = SAL2;
               2'b10: estado_sig = SAL3;
               2'b01: estado_sig = SAL1;
               default: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
            endcase
         end
         SAL3: begin
            case (par)
               2'b10: estado_sig = SAL3;
               2'b00: begin
                  estado_sig = IDLE;
                  r_sig      = 1'b1;
               end
               2'b11: estado_sig = SAL2;
               default: begin
                  estado_sig = ERR;
                  err_sig    = 1'b1;
               end
            endcase
         end
         ERR: begin
            // Silent until both beams are clear; no further err while held.
            if (par == 2'b00) estado_sig = IDLE;
         end
         default: estado_sig = IDLE;
      endcase
   end

endmodule

// File: tb/tb_detector_sentido.sv
// Directed bench for detector_sentido: table of sensor steps with expected pulse counts and end state,
// plus hand sequences for reset, bounce, latency and mid-passage reset.
module tb_detector_sentido;
   import detector_pkg::*;

   localparam int DEB = 4;
`ifdef DETECTOR_DEBOUNCE_EN
   localparam int LAT_ESP = 2 + DEB + 1;
`else
   localparam int LAT_ESP = 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sa  = 1'b0;
   logic sb  = 1'b0;
   logic s, r, err;

   int n_chk  = 0;
   int n_pass = 0;

   detector_sentido #(.DEB_CYCLES(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .sa  (sa),
      .sb  (sb),
      .s   (s),
      .r   (r),
      .err (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic    a;
      logic    b;
      int      ciclos;
      int      ns;
      int      nr;
      int      ne;
      estado_t est;
   } vec_t;

   vec_t tabla[25];

   task automatic chk(input string nombre, input int act, input int esp);
      n_chk++;
      if (act == esp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nombre, act, esp);
   endtask

   // Hold a sensor pair for n clocks, counting output pulses seen.
   task automatic paso(input logic a, input logic b, input int n,
                       output int ns, output int nr, output int ne, output int nboth);
      ns = 0; nr = 0; ne = 0; nboth = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         sa = a;
         sb = b;
         @(posedge clk);
         #1;
         if (s)     ns++;
         if (r)     nr++;
         if (err)   ne++;
         if (s & r) nboth++;
      end
   endtask

   initial begin
      int ns, nr, ne, nb, both_tot, lat, fa_alto, fa_mal, tot_s, tot_r, tot_e;
      logic prev;
      string tag;

      tabla[0]  = '{1'b1, 1'b0, 10, 0, 0, 0, ENT1};
      tabla[1]  = '{1'b1, 1'b1, 10, 0, 0, 0, ENT2};
      tabla[2]  = '{1'b0, 1'b1, 10, 0, 0, 0, ENT3};
      tabla[3]  = '{1'b0, 1'b0, 10, 1, 0, 0, IDLE};
      tabla[4]  = '{1'b0, 1'b1, 10, 0, 0, 0, SAL1};
      tabla[5]  = '{1'b1, 1'b1, 10, 0, 0, 0, SAL2};
      tabla[6]  = '{1'b1, 1'b0, 10, 0, 0, 0, SAL3};
      tabla[7]  = '{1'b0, 1'b0, 10, 0, 1, 0, IDLE};
      tabla[8]  = '{1'b1, 1'b0, 10, 0, 0, 0, ENT1};
      tabla[9]  = '{1'b0, 1'b0, 10, 0, 0, 0, IDLE};
      tabla[10] = '{1'b1, 1'b1, 20, 0, 0, 1, ERR};
      tabla[11] = '{1'b0, 1'b0, 10, 0, 0, 0, IDLE};
      tabla[12] = '{1'b1, 1'b0, 10, 0, 0, 0, ENT1};
      tabla[13] = '{1'b0, 1'b1, 10, 0, 0, 1, ERR};
      tabla[14] = '{1'b0, 1'b0, 10, 0, 0, 0, IDLE};
      tabla[15] = '{1'b1, 1'b0, 10, 0, 0, 0, ENT1};
      tabla[16] = '{1'b1, 1'b1, 10, 0, 0, 0, ENT2};
      tabla[17] = '{1'b1, 1'b0, 10, 0, 0, 0, ENT1};
      tabla[18] = '{1'b1, 1'b1, 10, 0, 0, 0, ENT2};
      tabla[19] = '{1'b0, 1'b1, 10, 0, 0, 0, ENT3};
      tabla[20] = '{1'b1, 1'b1, 10, 0, 0, 0, ENT2};
      tabla[21] = '{1'b0, 1'b1, 10, 0, 0, 0, ENT3};
      tabla[22] = '{1'b0, 1'b0, 10, 1, 0, 0, IDLE};
      tabla[23] = '{1'b0, 1'b1, 10, 0, 0, 0, SAL1};
      tabla[24] = '{1'b0, 1'b0, 10, 0, 0, 0, IDLE};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_s",      int'(s),          0);
      chk("rst_r",      int'(r),          0);
      chk("rst_err",    int'(err),        0);
      chk("rst_estado", int'(dut.estado), int'(IDLE));
      chk("rst_fa",     int'(dut.fa),     0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Table-driven passages
      both_tot = 0;
      for (int i = 0; i < 25; i++) begin
         paso(tabla[i].a, tabla[i].b, tabla[i].ciclos, ns, nr, ne, nb);
         both_tot += nb;
         tag = $sformatf("v%0d", i);
         chk({tag, "_s"},      ns,               tabla[i].ns);
         chk({tag, "_r"},      nr,               tabla[i].nr);
         chk({tag, "_err"},    ne,               tabla[i].ne);
         chk({tag, "_estado"}, int'(dut.estado), int'(tabla[i].est));
      end
      chk("s_and_r_together", both_tot, 0);

      // Entry latency from final raw release to s
      paso(1'b1, 1'b0, 10, ns, nr, ne, nb);
      paso(1'b1, 1'b1, 10, ns, nr, ne, nb);
      paso(1'b0, 1'b1, 10, ns, nr, ne, nb);
      @(negedge clk);
      sa = 1'b0;
      sb = 1'b0;
      lat = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (s) break;
      end
      chk("lat_s", lat, LAT_ESP);
      paso(1'b0, 1'b0, 12, ns, nr, ne, nb);
      chk("lat_no_second_s", ns, 0);
      chk("lat_estado", int'(dut.estado), int'(IDLE));

      // Bounce: sa toggles every 2 clocks for 20 clocks, then settles low
      fa_alto = 0; fa_mal = 0; tot_s = 0; tot_r = 0; tot_e = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         prev = sa;
         sa = (k < 20) ? ((k >> 1) % 2 == 0) : 1'b0;
         sb = 1'b0;
         @(posedge clk);
         #1;
         if (dut.fa) fa_alto++;
         if (dut.fa !== prev) fa_mal++;
         if (s)   tot_s++;
         if (r)   tot_r++;
         if (err) tot_e++;
      end
`ifdef DETECTOR_DEBOUNCE_EN
      chk("bounce_fa_high_cycles", fa_alto, 0);
`else
      chk("bounce_fa_follow_errors", fa_mal, 0);
      chk("bounce_fa_high_cycles", fa_alto, 10);
`endif
      paso(1'b0, 1'b0, 10, ns, nr, ne, nb);
      chk("bounce_s",      tot_s + ns, 0);
      chk("bounce_r",      tot_r + nr, 0);
      chk("bounce_err",    tot_e + ne, 0);
      chk("bounce_estado", int'(dut.estado), int'(IDLE));

      // Reset mid-passage while in ENT3
      paso(1'b1, 1'b0, 10, ns, nr, ne, nb);
      paso(1'b1, 1'b1, 10, ns, nr, ne, nb);
      paso(1'b0, 1'b1, 10, ns, nr, ne, nb);
      chk("pre_rst_estado", int'(dut.estado), int'(ENT3));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_estado", int'(dut.estado), int'(IDLE));
      chk("async_rst_fb",     int'(dut.fb),     0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      sa = 1'b0;
      sb = 1'b0;
      rst = 1'b0;
      paso(1'b0, 1'b0, 15, ns, nr, ne, nb);
      chk("post_rst_s",      ns, 0);
      chk("post_rst_r",      nr, 0);
      chk("post_rst_err",    ne, 0);
      chk("post_rst_estado", int'(dut.estado), int'(IDLE));

      tot_s = 0; tot_r = 0; tot_e = 0;
      paso(1'b1, 1'b0, 10, ns, nr, ne, nb); tot_s += ns; tot_r += nr; tot_e += ne;
      paso(1'b1, 1'b1, 10, ns, nr, ne, nb); tot_s += ns; tot_r += nr; tot_e += ne;
      paso(1'b0, 1'b1, 10, ns, nr, ne, nb); tot_s += ns; tot_r += nr; tot_e += ne;
      paso(1'b0, 1'b0, 10, ns, nr, ne, nb); tot_s += ns; tot_r += nr; tot_e += ne;
      chk("reentry_s",   tot_s, 1);
      chk("reentry_r",   tot_r, 0);
      chk("reentry_err", tot_e, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/detector_sentido.md
DETECTOR_SENTIDO -- requirements
Module: detector_sentido

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable clocks required before a debounced sensor changes (range 1..255).
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port sa, input, 1: outer beam sensor, async to clk; 1 = beam broken.
REQ-005 SHALL have port sb, input, 1: inner beam sensor, async to clk; 1 = beam broken.
REQ-006 SHALL have port s, output, 1: one-cycle entry pulse, feeding the up input of the downstream parking counter.
REQ-007 SHALL have port r, output, 1: one-cycle exit pulse, feeding the down input of the downstream parking counter.
REQ-008 SHALL have port err, output, 1: one-cycle pulse on an illegal sensor sequence.

Function
REQ-009 SHALL pass sa and sb each through a 2-flop synchronizer before any other use.
REQ-010 SHALL drive each filtered sensor (fa, fb) to the synchronized value only after it differs from the current filtered value for DEB_CYCLES consecutive clocks; the counter restarts at 0 on any bounce.
REQ-011 SHALL run the FSM on (fa,fb) with states IDLE, ENT1, ENT2, ENT3, SAL1, SAL2, SAL3, ERR.
REQ-012 SHALL transition from IDLE as follows: 10 -> ENT1; 01 -> SAL1; 11 -> ERR; 00 -> stay.
REQ-013 SHALL handle the entry path as follows: ENT1 goes 11 -> ENT2, 00 -> IDLE (back-out, no pulse); ENT2 goes 01 -> ENT3, 10 -> ENT1; ENT3 goes 00 -> IDLE with s=1, 11 -> ENT2.
REQ-014 SHALL mirror the entry path for exit: SAL1 goes 11 -> SAL2, 00 -> IDLE; SAL2 goes 10 -> SAL3, 01 -> SAL1; SAL3 goes 00 -> IDLE with r=1, 11 -> SAL2.
REQ-015 SHALL treat any (fa,fb) combination not listed for the current state (e.g. 01 in ENT1) as illegal: go to ERR, err=1 for that one cycle.
REQ-016 SHALL, entering ERR from IDLE on 11, also pulse err once; ERR SHALL hold until 00 and then go to IDLE, emitting no s or r.
REQ-017 SHALL register s, r and err; each is high exactly one clock, in the cycle after the FSM observes the completing transition.
REQ-018 SHALL never assert s and r in the same cycle; a full passage yields exactly one pulse.
REQ-019 SHALL produce, with debounce compiled in, s or r no earlier than 2+DEB_CYCLES+1 clocks after the final raw sensor release.

Reset
REQ-020 SHALL, when rst is asserted, immediately clear the synchronizers, debounce counters, fa/fb (0), FSM (IDLE), and s, r, err (0) without waiting for clk.
REQ-021 SHALL discard any in-progress passage on reset mid-sequence, emitting no pulse after release.
REQ-022 SHALL, after rst deasserts, take its first state update on the next rising clk edge.

Configuration
REQ-023 SHALL provide macro DETECTOR_DEBOUNCE_EN.
REQ-024 SHALL, when DETECTOR_DEBOUNCE_EN is defined, include the REQ-010 filter.
REQ-025 SHALL, when DETECTOR_DEBOUNCE_EN is undefined, have fa/fb equal the synchronizer outputs directly, make DEB_CYCLES unused, and preserve all FSM behaviour.

Structure
REQ-026 SHALL take the FSM state encoding (3-bit enum) and the DEB_CYCLES default constant from shared package detector_pkg.
REQ-027 SHALL implement the synchronizer plus debounce filter as sub-module filtro_rebote, instantiated once per sensor.
REQ-028 SHALL be 120-400 lines of RTL in total.

Verification
REQ-029 SHALL cover entry: sa=1 for 10 clocks, then both high 10, then sb only 10, then both low -> exactly one s pulse of 1 clock; r=0, err=0.
REQ-030 SHALL cover exit: sb 10, both 10, sa 10, release -> exactly one r pulse; s=0.
REQ-031 SHALL cover back-out: sa=1 for 10 clocks, then 0 -> no s, r or err; FSM back in IDLE.
REQ-032 SHALL cover bounce with DEB_CYCLES=4: sa toggles every 2 clocks for 20 clocks, then settles low -> fa stays 0, no pulses; repeat with the macro undefined -> fa follows the sync output.
REQ-033 SHALL cover an illegal sequence: from IDLE, sa and sb rise on the same clock -> one err pulse; then hold 20 clocks -> no further err; release -> IDLE, no s or r.
REQ-034 SHALL cover reset mid-operation: rst asserted for 3 clocks while in ENT3, then complete the release -> no s pulse; a following full entry -> one s.
